// File: rtl/boot_copier.sv
// boot_copier: copies WORD_COUNT words from boot ROM into RAM and holds the CPU in reset until the copy is done.
// Optional running checksum of the written image is enabled by defining BOOT_CHECKSUM_EN.
module boot_copier #(
  parameter logic [31:0] ROM_BASE     = 32'h0000_0000,
  parameter logic [31:0] RAM_BASE     = 32'h8000_0000,
  parameter int unsigned WORD_COUNT   = 1024,
  parameter bit          AUTO_START   = 1'b1
`ifdef BOOT_CHECKSUM_EN
  , parameter logic [31:0] EXPECTED_SUM = 32'h0000_0000
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        cpu_hold,
  output logic        read_op,
  output logic [31:0] bus_addr,
  input  logic [31:0] bus_data_read,
  output logic        write_op,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_data_write,
  input  logic        ram_ready
`ifdef BOOT_CHECKSUM_EN
  , output logic [31:0] checksum
  , output logic        checksum_ok
`endif
);

  localparam int IDX_W = (WORD_COUNT > 0) ? $clog2(WORD_COUNT + 1) : 1;

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, FIN} state_t;

  state_t           state, state_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic             auto_pend, auto_pend_d;
  logic             busy_d, done_d, cpu_hold_d, read_op_d, write_op_d;
  logic [31:0]      bus_addr_d, ram_addr_d, ram_data_write_d;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0]      checksum_d;
  logic             checksum_ok_d;
`endif

  // Word index to byte address; wraps modulo 2^32 by construction.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [IDX_W-1:0] i);
    return base + (32'(i) << 2);
  endfunction

  always_comb begin
    state_d          = state;
    idx_d            = idx;
    auto_pend_d      = auto_pend;
    busy_d           = busy;
    done_d           = done;
    cpu_hold_d       = cpu_hold;
    read_op_d        = 1'b0;
    write_op_d       = 1'b0;
    bus_addr_d       = bus_addr;
    ram_addr_d       = ram_addr;
    ram_data_write_d = ram_data_write;
`ifdef BOOT_CHECKSUM_EN
    checksum_d       = checksum;
    checksum_ok_d    = checksum_ok;
`endif
    case (state)
      IDLE: begin
        if (start || auto_pend) begin
          auto_pend_d = 1'b0;
          idx_d       = '0;
          done_d      = 1'b0;
          busy_d      = 1'b1;
`ifdef BOOT_CHECKSUM_EN
          checksum_d    = '0;
          checksum_ok_d = 1'b0;
`endif
          if (WORD_COUNT == 0) begin
            state_d = FIN;
          end else begin
            state_d    = RD;
            read_op_d  = 1'b1;
            bus_addr_d = word_addr(ROM_BASE, '0);
          end
        end
      end
      RD: state_d = CAP;
      CAP: begin
        // ROM data is valid exactly one cycle after the read strobe.
        ram_data_write_d = bus_data_read;
        ram_addr_d       = word_addr(RAM_BASE, idx);
        write_op_d       = 1'b1;
        state_d          = WR;
      end
      WR: begin
        if (ram_ready) begin
          idx_d = idx + IDX_W'(1);
`ifdef BOOT_CHECKSUM_EN
          checksum_d = checksum + ram_data_write;
`endif
          if (32'(idx_d) == WORD_COUNT) begin
            state_d = FIN;
          end else begin
            state_d    = RD;
            read_op_d  = 1'b1;
            bus_addr_d = word_addr(ROM_BASE, idx_d);
          end
        end else begin
          write_op_d = 1'b1;
        end
      end
      FIN: begin
        done_d     = 1'b1;
        cpu_hold_d = 1'b0;
        busy_d     = 1'b0;
`ifdef BOOT_CHECKSUM_EN
        checksum_ok_d = (checksum == EXPECTED_SUM);
`endif
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      idx            <= '0;
      auto_pend      <= AUTO_START;
      busy           <= 1'b0;
      done           <= 1'b0;
      cpu_hold       <= 1'b1;
      read_op        <= 1'b0;
      write_op       <= 1'b0;
      bus_addr       <= '0;
      ram_addr       <= '0;
      ram_data_write <= '0;
`ifdef BOOT_CHECKSUM_EN
      checksum       <= '0;
      checksum_ok    <= 1'b0;
`endif
    end else begin
      state          <= state_d;
      idx            <= idx_d;
      auto_pend      <= auto_pend_d;
      busy           <= busy_d;
      done           <= done_d;
      cpu_hold       <= cpu_hold_d;
      read_op        <= read_op_d;
      write_op       <= write_op_d;
      bus_addr       <= bus_addr_d;
      ram_addr       <= ram_addr_d;
      ram_data_write <= ram_data_write_d;
`ifdef BOOT_CHECKSUM_EN
      checksum       <= checksum_d;
      checksum_ok    <= checksum_ok_d;
`endif
    end
  end

endmodule
